// File: rtl/fifo_wr_serializer.sv
// fifo_wr_serializer
//   Write-side feeder for ip_fifo in the wr_clk domain. Accepts a wide word on
//   a valid/ready slave port and writes it into the FIFO as RATIO symbols of
//   WIDTH bits, least-significant symbol first, holding whenever the FIFO is
//   full.
//
//   Handshake: a word transfers on a rising wr_clk edge where s_valid and
//   s_ready are both 1. s_ready does not depend on s_valid. s_ready is 1 in
//   IDLE, and also in the cycle that writes the last symbol of a word, so a
//   waiting word is loaded with no idle cycle between words. On the FIFO side
//   a symbol is written on every edge where wr_en is 1. wr_en is ~full while a
//   word is in flight and 0 otherwise.
//
//   Optional feature: define FIFO_WR_SEQ_EN to add a SEQ state. Each word is
//   then preceded by a sequence symbol equal to the number of completed words
//   (WIDTH bits, wrapping).
//
// Parameters
//   WIDTH     symbol width (must equal ip_fifo WIDTH)
//   RATIO     symbols per input word, >= 2
// Ports
//   rst       in   async reset, active-high
//   wr_clk    in   clock (FIFO write clock)
//   s_valid   in   input word valid
//   s_ready   out  input word accepted when s_valid & s_ready at posedge
//   s_data    in   input word, WIDTH*RATIO bits
//   full      in   ip_fifo full
//   wr_en     out  ip_fifo write enable
//   din       out  ip_fifo write data, WIDTH bits
//   busy      out  a word is in flight (state != IDLE)
//   word_cnt  out  words fully written to the FIFO, wraps at 16 bits
module fifo_wr_serializer #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) (
  input  logic                     rst,
  input  logic                     wr_clk,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WIDTH*RATIO-1:0]   s_data,
  input  logic                     full,
  output logic                     wr_en,
  output logic [WIDTH-1:0]         din,
  output logic                     busy,
  output logic [15:0]              word_cnt
);

  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

`ifdef FIFO_WR_SEQ_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_SEQ = 2'd2} state_t;
  // A newly loaded word starts with its sequence symbol.
  localparam state_t ST_FIRST = ST_SEQ;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1} state_t;
  localparam state_t ST_FIRST = ST_SEND;
`endif

  state_t                   state;
  state_t                   state_next;
  logic [WIDTH*RATIO-1:0]   shreg;
  logic [IDX_W-1:0]         idx;
  logic                     load;
  logic                     shift;
  logic                     word_done;
`ifdef FIFO_WR_SEQ_EN
  logic [WIDTH-1:0]         seq_cnt;
`endif

  // Next state, handshake outputs and datapath controls.
  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    wr_en      = 1'b0;
    din        = '0;
    load       = 1'b0;
    shift      = 1'b0;
    word_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          load       = 1'b1;
          state_next = ST_FIRST;
        end
      end
      ST_SEND: begin
        wr_en = ~full;
        din   = shreg[WIDTH-1:0];
        if (!full) begin
          if (idx == IDX_LAST) begin
            // Last symbol leaves this edge, so the next word can be taken now.
            word_done = 1'b1;
            s_ready   = 1'b1;
            if (s_valid) begin
              load       = 1'b1;
              state_next = ST_FIRST;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            shift = 1'b1;
          end
        end
      end
`ifdef FIFO_WR_SEQ_EN
      ST_SEQ: begin
        wr_en = ~full;
        din   = seq_cnt;
        if (!full) state_next = ST_SEND;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
    // Async reset forces the state to IDLE at once. IDLE would otherwise
    // raise s_ready, so the outputs are also held quiet while rst is high.
    if (rst) begin
      s_ready = 1'b0;
      wr_en   = 1'b0;
      din     = '0;
    end
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      idx      <= '0;
      word_cnt <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        shreg <= s_data;
        idx   <= '0;
      end else if (shift) begin
        shreg <= shreg >> WIDTH;
        idx   <= idx + IDX_W'(1);
      end
      if (word_done) word_cnt <= word_cnt + 16'd1;
    end
  end

`ifdef FIFO_WR_SEQ_EN
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst)            seq_cnt <= '0;
    else if (word_done) seq_cnt <= seq_cnt + WIDTH'(1);
  end
`endif

endmodule

// File: tb/tb_fifo_wr_serializer.sv
module tb_fifo_wr_serializer;

  localparam int WIDTH = 8;
  localparam int RATIO = 4;

  logic         rst;
  logic         wr_clk;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         full;
  logic         wr_en;
  logic [7:0]   din;
  logic         busy;
  logic [15:0]  word_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  fifo_wr_serializer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
    .rst      (rst),
    .wr_clk   (wr_clk),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .full     (full),
    .wr_en    (wr_en),
    .din      (din),
    .busy     (busy),
    .word_cnt (word_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // Pending symbols of accepted words in write order; last_q marks the final
  // data symbol of each word. cnt_m counts completed words since reset.
  logic [WIDTH-1:0] exp_q[$];
  bit               last_q[$];
  logic [15:0]      cnt_m;

  always @(negedge wr_clk) begin
    if (rst) begin
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_din", 32'(din), 32'd0);
      chk("rst_word_cnt", 32'(word_cnt), 32'd0);
      exp_q.delete();
      last_q.delete();
      cnt_m = 16'd0;
    end else begin
      int  pending;
      bit  e_wr, e_rdy;
      logic [31:0] w;
      pending = exp_q.size();
      e_wr  = (pending != 0) && !full;
      e_rdy = (pending == 0) || (pending == 1 && !full);
      chk("m_wr_en", 32'(wr_en), 32'(e_wr));
      chk("m_s_ready", 32'(s_ready), 32'(e_rdy));
      chk("m_busy", 32'(busy), 32'(pending != 0));
      chk("m_word_cnt", 32'(word_cnt), 32'(cnt_m));
      if (wr_en && full) chk("m_wr_while_full", 32'(wr_en), 32'd0);
      if (pending != 0) chk("m_din", 32'(din), 32'(exp_q[0]));
      // Effects of the coming rising edge.
      if (e_wr) begin
        void'(exp_q.pop_front());
        if (last_q.pop_front()) cnt_m = cnt_m + 16'd1;
      end
      if (s_valid && e_rdy) begin
        w = s_data;
`ifdef FIFO_WR_SEQ_EN
        exp_q.push_back(cnt_m[WIDTH-1:0]);
        last_q.push_back(1'b0);
`endif
        for (int k = 0; k < RATIO; k++) begin
          exp_q.push_back(w[k*WIDTH +: WIDTH]);
          last_q.push_back(k == RATIO - 1);
        end
      end
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst;
    logic        s_valid;
    logic [31:0] s_data;
    logic        full;
    logic        exp_wr_en;
    logic [7:0]  exp_din;
    logic        chk_din;
    logic        exp_s_ready;
    logic        exp_busy;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic sv, input logic [31:0] sd,
                              input logic f, input logic ew, input logic [7:0] ed,
                              input logic cd, input logic er, input logic eb,
                              input logic [15:0] ec);
    vec_t v;
    v.rst = r; v.s_valid = sv; v.s_data = sd; v.full = f;
    v.exp_wr_en = ew; v.exp_din = ed; v.chk_din = cd;
    v.exp_s_ready = er; v.exp_busy = eb; v.exp_cnt = ec;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic r, input logic sv, input logic [31:0] sd, input logic f);
    rst = r; s_valid = sv; s_data = sd; full = f;
  endtask

  logic [7:0] got[$];
  logic [7:0] want[$];

  initial begin
    drive(1'b1, 1'b0, 32'd0, 1'b0);

`ifdef FIFO_WR_SEQ_EN
    add(1, 0, 32'h0,        0, 0, 8'h00, 1, 0, 0, 16'd0);
    add(0, 1, 32'h44332211, 0, 0, 8'h00, 0, 1, 0, 16'd0);
    add(0, 1, 32'h88776655, 0, 1, 8'h00, 1, 0, 1, 16'd0);
    add(0, 1, 32'h88776655, 0, 1, 8'h11, 1, 0, 1, 16'd0);
    add(0, 1, 32'h88776655, 0, 1, 8'h22, 1, 0, 1, 16'd0);
    add(0, 1, 32'h88776655, 0, 1, 8'h33, 1, 0, 1, 16'd0);
    add(0, 1, 32'h88776655, 0, 1, 8'h44, 1, 1, 1, 16'd0);
    add(0, 0, 32'h0,        0, 1, 8'h01, 1, 0, 1, 16'd1);
    add(0, 0, 32'h0,        0, 1, 8'h55, 1, 0, 1, 16'd1);
    add(0, 0, 32'h0,        0, 1, 8'h66, 1, 0, 1, 16'd1);
    add(0, 0, 32'h0,        0, 1, 8'h77, 1, 0, 1, 16'd1);
    add(0, 0, 32'h0,        0, 1, 8'h88, 1, 1, 1, 16'd1);
    add(0, 0, 32'h0,        0, 0, 8'h00, 0, 1, 0, 16'd2);
`else
    // single word
    add(1, 0, 32'h0,        0, 0, 8'h00, 1, 0, 0, 16'd0);
    add(0, 1, 32'h44332211, 0, 0, 8'h00, 0, 1, 0, 16'd0);
    add(0, 0, 32'h0,        0, 1, 8'h11, 1, 0, 1, 16'd0);
    add(0, 0, 32'h0,        0, 1, 8'h22, 1, 0, 1, 16'd0);
    add(0, 0, 32'h0,        0, 1, 8'h33, 1, 0, 1, 16'd0);
    add(0, 0, 32'h0,        0, 1, 8'h44, 1, 1, 1, 16'd0);
    // back-to-back words, s_valid held
    add(0, 1, 32'h44332211, 0, 0, 8'h00, 0, 1, 0, 16'd1);
    add(0, 1, 32'h88776655, 0, 1, 8'h11, 1, 0, 1, 16'd1);
    add(0, 1, 32'h88776655, 0, 1, 8'h22, 1, 0, 1, 16'd1);
    add(0, 1, 32'h88776655, 0, 1, 8'h33, 1, 0, 1, 16'd1);
    add(0, 1, 32'h88776655, 0, 1, 8'h44, 1, 1, 1, 16'd1);
    add(0, 0, 32'h0,        0, 1, 8'h55, 1, 0, 1, 16'd2);
    add(0, 0, 32'h0,        0, 1, 8'h66, 1, 0, 1, 16'd2);
    add(0, 0, 32'h0,        0, 1, 8'h77, 1, 0, 1, 16'd2);
    add(0, 0, 32'h0,        0, 1, 8'h88, 1, 1, 1, 16'd2);
    // full held for three cycles while 33 is presented
    add(0, 1, 32'h44332211, 0, 0, 8'h00, 0, 1, 0, 16'd3);
    add(0, 0, 32'h0,        0, 1, 8'h11, 1, 0, 1, 16'd3);
    add(0, 0, 32'h0,        0, 1, 8'h22, 1, 0, 1, 16'd3);
    add(0, 0, 32'h0,        1, 0, 8'h33, 1, 0, 1, 16'd3);
    add(0, 0, 32'h0,        1, 0, 8'h33, 1, 0, 1, 16'd3);
    add(0, 0, 32'h0,        1, 0, 8'h33, 1, 0, 1, 16'd3);
    add(0, 0, 32'h0,        0, 1, 8'h33, 1, 0, 1, 16'd3);
    add(0, 0, 32'h0,        0, 1, 8'h44, 1, 1, 1, 16'd3);
    add(0, 0, 32'h0,        0, 0, 8'h00, 0, 1, 0, 16'd4);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge wr_clk); #1;
      drive(vecs[i].rst, vecs[i].s_valid, vecs[i].s_data, vecs[i].full);
      @(negedge wr_clk);
      chk($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].exp_wr_en));
      chk($sformatf("v%0d_s_ready", i), 32'(s_ready), 32'(vecs[i].exp_s_ready));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      chk($sformatf("v%0d_word_cnt", i), 32'(word_cnt), 32'(vecs[i].exp_cnt));
      if (vecs[i].chk_din) chk($sformatf("v%0d_din", i), 32'(din), 32'(vecs[i].exp_din));
    end

    // Reset in the middle of a word, then a fresh word.
    @(posedge wr_clk); #1; drive(1'b0, 1'b1, 32'h44332211, 1'b0);
    @(posedge wr_clk); #1; drive(1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge wr_clk); #1; drive(1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    chk("midrst_word_cnt", 32'(word_cnt), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_s_ready", 32'(s_ready), 32'd0);
    @(posedge wr_clk); #1; drive(1'b0, 1'b1, 32'hAABBCCDD, 1'b0);
    @(posedge wr_clk); #1; drive(1'b0, 1'b0, 32'h0, 1'b0);
`ifdef FIFO_WR_SEQ_EN
    want.push_back(8'h00);
`endif
    want.push_back(8'hDD); want.push_back(8'hCC);
    want.push_back(8'hBB); want.push_back(8'hAA);
    for (int c = 0; c < 10; c++) begin
      @(negedge wr_clk);
      if (wr_en) got.push_back(din);
    end
    chk("postrst_sym_count", 32'(got.size()), 32'(want.size()));
    for (int k = 0; k < want.size() && k < got.size(); k++)
      chk($sformatf("postrst_sym%0d", k), 32'(got[k]), 32'(want[k]));

    // Randomized traffic; the model above checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(posedge wr_clk); #1;
      drive(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 3) != 0),
            $urandom,
            ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 15 : 60)));
    end
    @(posedge wr_clk); #1; drive(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (12) @(posedge wr_clk);
    @(negedge wr_clk);
    chk("drain_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
